uop_inject_fsm: RTL and testbench
=================================

// Module: uop_inject_fsm
// PURPOSE
//  Parametrised micro-op injection FSM in the decode stage.
//  - Generalises the RTI-only sequencer to three modes: RTI, RET and hardware interrupt entry (INT).
//  - On a trigger it emits a fixed stack micro-op sequence, then a configurable NOP tail.
//  - Holds fetch/decode stalled for the whole sequence.
//  - Latches an interrupt request that arrives while a sequence is in flight.
// PARAMETERS
//  INSTR_W         16                     width of injected instruction word
//  NOP_CYCLES      4                      NOP tail length after the stack ops; legal 0..15
//  POP_PC_HIGH_OP  16'b0110000010001001   pop PC high word
//  POP_PC_LOW_OP   16'b0110000010001000   pop PC low word
//  POP_CCR_OP      16'hFFFF               pop CCR
//  PUSH_PC_LOW_OP  16'b0110000000001000   push PC low word
//  PUSH_PC_HIGH_OP 16'b0110000000001001   push PC high word
//  PUSH_CCR_OP     16'hFFFE               push CCR
//  NOP_OP          16'h0000               NOP / idle word
// PORTS
//  clk        in   1        rising-edge clock
//  reset      in   1        asynchronous, active-low reset
//  rti        in   1        RTI decoded; sampled in IDLE only
//  ret        in   1        RET decoded; sampled in IDLE only
//  int_req    in   1        interrupt request; sampled every cycle
//  out        out  INSTR_W  injected instruction word to the decode latch
//  stall      out  1        1 = hold PC and fetch latch
//  mode       out  2        active sequence: 00 none, 01 RTI, 10 RET, 11 INT
//  done       out  1        1 in the last stall cycle of a sequence
// BEHAVIOUR
//  - All outputs are registered. Reset low: out=NOP_OP, stall=0, mode=00, done=0, int_pending=0, FSM=IDLE.
//  - Reset low mid-sequence aborts immediately to IDLE; it does not wait for a clock.
//  - States: IDLE, OP1, OP2, OP3, NOP.
//  - Sequences:
//      RTI: POP_PC_HIGH, POP_PC_LOW, POP_CCR, then NOP_CYCLES x NOP_OP
//      RET: POP_PC_HIGH, POP_PC_LOW, then NOP_CYCLES x NOP_OP (OP3 skipped)
//      INT: PUSH_PC_LOW, PUSH_PC_HIGH, PUSH_CCR, then NOP_CYCLES x NOP_OP
//  - Latency: trigger sampled at rising edge k -> first op on out with stall=1 from edge k until edge k+1.
//  - Stall length: 3+NOP_CYCLES cycles (RTI/INT), 2+NOP_CYCLES cycles (RET).
//    stall and mode are constant for the whole sequence.
//  - NOP counter: 4 bits, loaded with NOP_CYCLES-1 on entering NOP, decremented each cycle, exits at 0.
//    NOP_CYCLES=0 skips the NOP state entirely.
//  - done=1 only in the final cycle of the sequence (last NOP, or last op when NOP_CYCLES=0).
//  - Simultaneous triggers in IDLE: priority int_req > rti > ret; lower-priority triggers are dropped.
//  - rti/ret while busy are ignored; the stalled pipeline cannot legally produce them.
//  - int_req high at any edge while busy sets int_pending.
//    At the edge ending a sequence: if int_pending or int_req, clear int_pending and go straight to INT OP1.
//    No IDLE cycle is inserted; stall stays 1.
//  - int_req seen during an INT sequence is also latched: back-to-back INT entry is allowed.
//  - IDLE: out=NOP_OP, stall=0, mode=00, done=0.
//  - Triggers are level-sampled. A level still high at the IDLE edge after done retriggers.
// TESTING
//  1. Reset low 2 cycles then high, no triggers -> out=0, stall=0, mode=00 every cycle.
//  2. rti=1 one cycle -> 7 cycles: 6089h, 6088h, FFFFh, 0, 0, 0, 0 with stall=1, mode=01;
//     done only in cycle 7; then out=0, stall=0.
//  3. ret=1 one cycle -> 6089h, 6088h, then 4 NOPs, stall=1 for 6 cycles, mode=10.
//  4. rti and int_req high in the same idle cycle -> INT sequence 6008h, 6009h, FFFEh, 4 NOPs, mode=11;
//     rti dropped.
//  5. rti sequence, int_req pulsed in cycle 2 -> after cycle 7, next cycle is 6008h with stall still 1;
//     no idle gap between the two sequences.
//  6. Reset low in cycle 3 of an RTI sequence -> out=0, stall=0 before the next edge.
//     Rebuild with NOP_CYCLES=0: RTI stalls exactly 3 cycles, with done=1 on the FFFFh cycle.

Source files
------------

// File: rtl/uop_inject_fsm.sv
// Decode-stage micro-op injector: RTI / RET / interrupt-entry stack sequences followed by a NOP tail.
// Trigger at edge k drives the first op from edge k; stall holds fetch for the whole sequence (no handshake).
module uop_inject_fsm #(
  parameter int                 INSTR_W         = 16,
  parameter int                 NOP_CYCLES      = 4,
  parameter logic [INSTR_W-1:0] POP_PC_HIGH_OP  = 16'b0110000010001001,
  parameter logic [INSTR_W-1:0] POP_PC_LOW_OP   = 16'b0110000010001000,
  parameter logic [INSTR_W-1:0] POP_CCR_OP      = 16'hFFFF,
  parameter logic [INSTR_W-1:0] PUSH_PC_LOW_OP  = 16'b0110000000001000,
  parameter logic [INSTR_W-1:0] PUSH_PC_HIGH_OP = 16'b0110000000001001,
  parameter logic [INSTR_W-1:0] PUSH_CCR_OP     = 16'hFFFE,
  parameter logic [INSTR_W-1:0] NOP_OP          = 16'h0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rti,
  input  logic               ret,
  input  logic               int_req,
  output logic [INSTR_W-1:0] out,
  output logic               stall,
  output logic [1:0]         mode,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OP1,
    S_OP2,
    S_OP3,
    S_NOP
  } state_t;

  localparam logic [1:0] M_NONE = 2'b00;
  localparam logic [1:0] M_RTI  = 2'b01;
  localparam logic [1:0] M_RET  = 2'b10;
  localparam logic [1:0] M_INT  = 2'b11;

  localparam bit         HAS_TAIL = (NOP_CYCLES != 0);
  localparam logic [3:0] NOP_LOAD = HAS_TAIL ? 4'(NOP_CYCLES - 1) : 4'd0;

  state_t               state_q, state_d;
  logic [3:0]           nop_cnt_q, nop_cnt_d;
  logic                 int_pending_q, int_pending_d;
  logic [1:0]           mode_d;
  logic                 seq_end;
  logic [INSTR_W-1:0]   out_d;
  logic                 stall_d;
  logic                 done_d;

  // State and output registers; the mode output doubles as the active-sequence register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      nop_cnt_q     <= 4'd0;
      int_pending_q <= 1'b0;
      out           <= NOP_OP;
      stall         <= 1'b0;
      mode          <= M_NONE;
      done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      nop_cnt_q     <= nop_cnt_d;
      int_pending_q <= int_pending_d;
      out           <= out_d;
      stall         <= stall_d;
      mode          <= mode_d;
      done          <= done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    mode_d        = mode;
    nop_cnt_d     = nop_cnt_q;
    int_pending_d = int_pending_q | int_req;
    seq_end       = 1'b0;

    case (state_q)
      S_IDLE: begin
        int_pending_d = 1'b0;
        mode_d        = M_NONE;
        if (int_req) begin
          state_d = S_OP1;
          mode_d  = M_INT;
        end else if (rti) begin
          state_d = S_OP1;
          mode_d  = M_RTI;
        end else if (ret) begin
          state_d = S_OP1;
          mode_d  = M_RET;
        end
      end
      S_OP1: state_d = S_OP2;
      S_OP2: begin
        if (mode != M_RET) begin
          state_d = S_OP3;
        end else if (HAS_TAIL) begin
          state_d   = S_NOP;
          nop_cnt_d = NOP_LOAD;
        end else begin
          seq_end = 1'b1;
        end
      end
      S_OP3: begin
        if (HAS_TAIL) begin
          state_d   = S_NOP;
          nop_cnt_d = NOP_LOAD;
        end else begin
          seq_end = 1'b1;
        end
      end
      S_NOP: begin
        if (nop_cnt_q == 4'd0) begin
          seq_end = 1'b1;
        end else begin
          nop_cnt_d = nop_cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A pending or fresh interrupt chains straight into INT entry without an idle cycle.
    if (seq_end) begin
      int_pending_d = 1'b0;
      if (int_pending_q || int_req) begin
        state_d = S_OP1;
        mode_d  = M_INT;
      end else begin
        state_d = S_IDLE;
        mode_d  = M_NONE;
      end
    end
  end

  always_comb begin
    out_d   = NOP_OP;
    stall_d = (state_d != S_IDLE);
    done_d  = 1'b0;
    case (state_d)
      S_OP1: out_d = (mode_d == M_INT) ? PUSH_PC_LOW_OP : POP_PC_HIGH_OP;
      S_OP2: begin
        out_d  = (mode_d == M_INT) ? PUSH_PC_HIGH_OP : POP_PC_LOW_OP;
        done_d = !HAS_TAIL && (mode_d == M_RET);
      end
      S_OP3: begin
        out_d  = (mode_d == M_INT) ? PUSH_CCR_OP : POP_CCR_OP;
        done_d = !HAS_TAIL;
      end
      S_NOP:   done_d = (nop_cnt_d == 4'd0);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uop_inject_fsm.sv
// Scoreboard bench for uop_inject_fsm: default 4-NOP tail instance plus a zero-tail instance on shared inputs.
module tb_uop_inject_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, rti, ret, int_req;
  logic [15:0] out, out0;
  logic        stall, stall0, done, done0;
  logic [1:0]  mode, mode0;

  typedef struct packed {
    logic [15:0] out;
    logic        stall;
    logic [1:0]  mode;
    logic        done;
  } exp_t;

  exp_t sb[$];
  exp_t sb0[$];
  int   vectors = 0;
  int   miscompares = 0;

  uop_inject_fsm dut (
    .clk(clk), .reset(reset), .rti(rti), .ret(ret), .int_req(int_req),
    .out(out), .stall(stall), .mode(mode), .done(done)
  );

  uop_inject_fsm #(.NOP_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .rti(rti), .ret(ret), .int_req(int_req),
    .out(out0), .stall(stall0), .mode(mode0), .done(done0)
  );

  // Reference sequences: stack ops per mode, then the NOP tail, done on the final cycle.
  task automatic push_seq(input bit tail0, input logic [1:0] m);
    logic [15:0] ops [3];
    int   n;
    int   nops;
    exp_t e;
    nops = tail0 ? 0 : 4;
    n    = (m == 2'b10) ? 2 : 3;
    if (m == 2'b11) begin
      ops[0] = 16'h6008; ops[1] = 16'h6009; ops[2] = 16'hFFFE;
    end else begin
      ops[0] = 16'h6089; ops[1] = 16'h6088; ops[2] = 16'hFFFF;
    end
    for (int i = 0; i < n + nops; i++) begin
      e.out   = (i < n) ? ops[i] : 16'h0000;
      e.stall = 1'b1;
      e.mode  = m;
      e.done  = (i == n + nops - 1);
      if (tail0) sb0.push_back(e);
      else       sb.push_back(e);
    end
  endtask

  task automatic push_idle(input bit tail0);
    exp_t e;
    e = '{16'h0000, 1'b0, 2'b00, 1'b0};
    if (tail0) sb0.push_back(e);
    else       sb.push_back(e);
  endtask

  task automatic test_reset;
    exp_t e, g;
    e = '{16'h0000, 1'b0, 2'b00, 1'b0};
    reset = 1'b0; rti = 1'b0; ret = 1'b0; int_req = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 3) reset = 1'b1;
      g = {out, stall, mode, done};
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL reset cyc%0d: got %h/%b/%b/%b want %h/%b/%b/%b", c,
                 g.out, g.stall, g.mode, g.done, e.out, e.stall, e.mode, e.done);
      end
      g = {out0, stall0, mode0, done0};
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL reset_tail0 cyc%0d: got %h/%b/%b/%b want %h/%b/%b/%b", c,
                 g.out, g.stall, g.mode, g.done, e.out, e.stall, e.mode, e.done);
      end
    end
  endtask

  // Pulses the given trigger pattern for one cycle and drains both scoreboards.
  task automatic run_trigger(input string name, input logic t_rti, input logic t_ret,
                             input logic t_int);
    exp_t e, g;
    int   c;
    repeat (2) @(negedge clk);
    rti = t_rti; ret = t_ret; int_req = t_int;
    @(negedge clk);
    rti = 1'b0; ret = 1'b0; int_req = 1'b0;
    c = 0;
    while (sb.size() > 0 || sb0.size() > 0) begin
      c++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        g = {out, stall, mode, done};
        vectors++;
        if (g !== e) begin
          miscompares++;
          $display("FAIL %s cyc%0d: got %h/%b/%b/%b want %h/%b/%b/%b", name, c,
                   g.out, g.stall, g.mode, g.done, e.out, e.stall, e.mode, e.done);
        end
      end
      if (sb0.size() > 0) begin
        e = sb0.pop_front();
        g = {out0, stall0, mode0, done0};
        vectors++;
        if (g !== e) begin
          miscompares++;
          $display("FAIL %s_tail0 cyc%0d: got %h/%b/%b/%b want %h/%b/%b/%b", name, c,
                   g.out, g.stall, g.mode, g.done, e.out, e.stall, e.mode, e.done);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rti;
    push_seq(1'b0, 2'b01); push_idle(1'b0); push_idle(1'b0);
    push_seq(1'b1, 2'b01); push_idle(1'b1);
    run_trigger("rti", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_ret;
    push_seq(1'b0, 2'b10); push_idle(1'b0);
    push_seq(1'b1, 2'b10); push_idle(1'b1);
    run_trigger("ret", 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_priority;
    push_seq(1'b0, 2'b11); push_idle(1'b0);
    push_seq(1'b1, 2'b11); push_idle(1'b1);
    run_trigger("prio_int_rti", 1'b1, 1'b0, 1'b1);
    push_seq(1'b0, 2'b01); push_idle(1'b0);
    push_seq(1'b1, 2'b01); push_idle(1'b1);
    run_trigger("prio_rti_ret", 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back;
    exp_t e, g;
    int   c;
    push_seq(1'b0, 2'b01); push_seq(1'b0, 2'b11); push_idle(1'b0);
    push_seq(1'b1, 2'b01); push_seq(1'b1, 2'b11); push_idle(1'b1);
    repeat (2) @(negedge clk);
    rti = 1'b1;
    @(negedge clk);
    rti = 1'b0;
    c = 0;
    while (sb.size() > 0 || sb0.size() > 0) begin
      c++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        g = {out, stall, mode, done};
        vectors++;
        if (g !== e) begin
          miscompares++;
          $display("FAIL b2b cyc%0d: got %h/%b/%b/%b want %h/%b/%b/%b", c,
                   g.out, g.stall, g.mode, g.done, e.out, e.stall, e.mode, e.done);
        end
      end
      if (sb0.size() > 0) begin
        e = sb0.pop_front();
        g = {out0, stall0, mode0, done0};
        vectors++;
        if (g !== e) begin
          miscompares++;
          $display("FAIL b2b_tail0 cyc%0d: got %h/%b/%b/%b want %h/%b/%b/%b", c,
                   g.out, g.stall, g.mode, g.done, e.out, e.stall, e.mode, e.done);
        end
      end
      int_req = (c == 2);
      @(negedge clk);
    end
    int_req = 1'b0;
  endtask

  // rti held high: one idle cycle after done, then the level retriggers.
  task automatic test_retrigger;
    exp_t e, g;
    int   c;
    push_seq(1'b0, 2'b01); push_idle(1'b0); push_seq(1'b0, 2'b01); push_idle(1'b0);
    repeat (2) @(negedge clk);
    rti = 1'b1;
    @(negedge clk);
    c = 0;
    while (sb.size() > 0) begin
      c++;
      e = sb.pop_front();
      g = {out, stall, mode, done};
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL retrigger cyc%0d: got %h/%b/%b/%b want %h/%b/%b/%b", c,
                 g.out, g.stall, g.mode, g.done, e.out, e.stall, e.mode, e.done);
      end
      if (c == 9) rti = 1'b0;
      @(negedge clk);
    end
    rti = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_abort;
    exp_t e, g;
    push_seq(1'b0, 2'b01);
    repeat (2) @(negedge clk);
    rti = 1'b1;
    @(negedge clk);
    rti = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      e = sb.pop_front();
      g = {out, stall, mode, done};
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL abort_pre cyc%0d: got %h/%b/%b/%b want %h/%b/%b/%b", c,
                 g.out, g.stall, g.mode, g.done, e.out, e.stall, e.mode, e.done);
      end
      if (c < 3) @(negedge clk);
    end
    sb.delete();
    e = '{16'h0000, 1'b0, 2'b00, 1'b0};
    reset = 1'b0;
    #1;
    g = {out, stall, mode, done};
    vectors++;
    if (g !== e) begin
      miscompares++;
      $display("FAIL abort_async: got %h/%b/%b/%b want %h/%b/%b/%b",
               g.out, g.stall, g.mode, g.done, e.out, e.stall, e.mode, e.done);
    end
    #2;
    reset = 1'b1;
    @(negedge clk);
    g = {out, stall, mode, done};
    vectors++;
    if (g !== e) begin
      miscompares++;
      $display("FAIL abort_after: got %h/%b/%b/%b want %h/%b/%b/%b",
               g.out, g.stall, g.mode, g.done, e.out, e.stall, e.mode, e.done);
    end
    g = {out0, stall0, mode0, done0};
    vectors++;
    if (g !== e) begin
      miscompares++;
      $display("FAIL abort_after_tail0: got %h/%b/%b/%b want %h/%b/%b/%b",
               g.out, g.stall, g.mode, g.done, e.out, e.stall, e.mode, e.done);
    end
  endtask

  initial begin
    test_reset;
    test_rti;
    test_ret;
    test_priority;
    test_back_to_back;
    test_retrigger;
    test_reset_abort;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
